// File: rtl/motion_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motion_pkg
// Description : Shared geometry, pixel/bank types and writer states for the
//               motion frame store.
// Revision    : 1.0 - initial release
// ============================================================================
package motion_pkg;
    localparam int IMG_W   = 160;
    localparam int IMG_H   = 120;
    localparam int PIX_CNT = IMG_W * IMG_H;
    localparam int ADDR_W  = $clog2(PIX_CNT);
    localparam int DATA_W  = 16;

    typedef logic [DATA_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [1:0]        bank_t;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_WRITE = 2'd1,
        WR_FULL  = 2'd2
    } wr_state_t;

    localparam addr_t c_pix_cnt  = addr_t'(PIX_CNT);
    localparam addr_t c_last_pix = addr_t'(PIX_CNT - 1);
endpackage
`default_nettype wire

// File: rtl/frame_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : frame_bank_ram
// Description : One frame bank: simple dual-port RAM, one write port and one
//               registered read port, PIX_CNT x DATA_W.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_bank_ram
    import motion_pkg::*;
(
    input  logic   clk,
    input  logic   wr_en,
    input  addr_t  wr_addr,
    input  pixel_t wr_data,
    input  logic   rd_en,
    input  addr_t  rd_addr,
    output pixel_t rd_data
);
    pixel_t r_mem [0:PIX_CNT-1];
    pixel_t r_rd_data;

    // No reset on the array or read register so the store maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;
endmodule
`default_nettype wire

// File: rtl/motion_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : motion_frame_buffer
// Description : Triple-bank frame store feeding the motion core with the two
//               latest complete frames; rotation deferred to display start.
// Revision    : 1.0 - initial release
// ============================================================================
module motion_frame_buffer
    import motion_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_sof,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_frame_start,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] prev_data,
    output logic [DATA_W-1:0] curr_data,
    output logic              frame_valid,
    output logic              short_err,
    output logic              ovf_err,
    output logic [7:0]        drop_cnt
);
    wr_state_t r_state;
    addr_t     r_wr_ptr;
    logic      r_pending;
    bank_t     r_wr_bank;
    bank_t     r_curr_bank;
    bank_t     r_prev_bank;
    logic [1:0] r_swaps;
    logic      r_frame_valid;
    logic      r_short_err;
    logic      r_ovf_err;
    logic [7:0] r_drop_cnt;
    logic      r_rd_ok;
    bank_t     r_rd_curr_bank;
    bank_t     r_rd_prev_bank;

    logic      w_rotate;
    bank_t     w_tgt_bank;
    logic      w_wr_en;
    addr_t     w_wr_addr;
    logic      w_rd_en;
    pixel_t    w_rd_data [3];
    pixel_t    w_curr_pix;
    pixel_t    w_prev_pix;

    // Pending only exists in FULL, so a rotation coinciding with wr_sof
    // steers pixel 0 of the new frame into the bank being freed.
    assign w_rotate   = rd_frame_start & r_pending;
    assign w_tgt_bank = w_rotate ? r_prev_bank : r_wr_bank;
    assign w_rd_en    = (rd_addr < c_pix_cnt);

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_wr_ptr;
        if (wr_sof && wr_valid && (r_state != WR_IDLE || wr_sof)) begin
            w_wr_en   = 1'b1;
            w_wr_addr = '0;
        end else if (r_state == WR_WRITE && wr_valid) begin
            w_wr_en = 1'b1;
        end
    end

    for (genvar b = 0; b < 3; b++) begin : g_bank
        frame_bank_ram u_ram (
            .clk     (clk),
            .wr_en   (w_wr_en && (w_tgt_bank == bank_t'(b))),
            .wr_addr (w_wr_addr),
            .wr_data (wr_data),
            .rd_en   (w_rd_en),
            .rd_addr (rd_addr),
            .rd_data (w_rd_data[b])
        );
    end

    always_comb begin
        w_curr_pix = '0;
        w_prev_pix = '0;
        case (r_rd_curr_bank)
            2'd0:    w_curr_pix = w_rd_data[0];
            2'd1:    w_curr_pix = w_rd_data[1];
            2'd2:    w_curr_pix = w_rd_data[2];
            default: w_curr_pix = '0;
        endcase
        case (r_rd_prev_bank)
            2'd0:    w_prev_pix = w_rd_data[0];
            2'd1:    w_prev_pix = w_rd_data[1];
            2'd2:    w_prev_pix = w_rd_data[2];
            default: w_prev_pix = '0;
        endcase
    end

    assign curr_data   = r_rd_ok ? w_curr_pix : '0;
    assign prev_data   = r_rd_ok ? w_prev_pix : '0;
    assign frame_valid = r_frame_valid;
    assign short_err   = r_short_err;
    assign ovf_err     = r_ovf_err;
    assign drop_cnt    = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= WR_IDLE;
            r_wr_ptr       <= '0;
            r_pending      <= 1'b0;
            r_wr_bank      <= 2'd0;
            r_curr_bank    <= 2'd1;
            r_prev_bank    <= 2'd2;
            r_swaps        <= 2'd0;
            r_frame_valid  <= 1'b0;
            r_short_err    <= 1'b0;
            r_ovf_err      <= 1'b0;
            r_drop_cnt     <= 8'd0;
            r_rd_ok        <= 1'b0;
            r_rd_curr_bank <= 2'd1;
            r_rd_prev_bank <= 2'd2;
        end else begin
            // Select travels with the address so in-flight reads use old banks.
            r_rd_ok        <= w_rd_en;
            r_rd_curr_bank <= r_curr_bank;
            r_rd_prev_bank <= r_prev_bank;

            if (w_rotate) begin
                r_prev_bank <= r_curr_bank;
                r_curr_bank <= r_wr_bank;
                r_wr_bank   <= r_prev_bank;
                r_pending   <= 1'b0;
                if (r_swaps != 2'd2) begin
                    r_swaps <= r_swaps + 2'd1;
                end
                r_frame_valid <= r_frame_valid | (r_swaps != 2'd0);
            end

            case (r_state)
                WR_IDLE: begin
                    if (wr_sof) begin
                        r_state  <= WR_WRITE;
                        r_wr_ptr <= wr_valid ? addr_t'(1) : '0;
                    end
                end
                WR_WRITE: begin
                    if (wr_sof) begin
                        r_short_err <= 1'b1;
                        r_wr_ptr    <= wr_valid ? addr_t'(1) : '0;
                    end else if (wr_valid) begin
                        r_wr_ptr <= r_wr_ptr + addr_t'(1);
                        if (r_wr_ptr == c_last_pix) begin
                            r_state   <= WR_FULL;
                            r_pending <= 1'b1;
                        end
                    end
                end
                WR_FULL: begin
                    if (wr_sof) begin
                        r_state  <= WR_WRITE;
                        r_wr_ptr <= wr_valid ? addr_t'(1) : '0;
                        if (r_pending && !w_rotate) begin
                            r_pending <= 1'b0;
                            if (r_drop_cnt != 8'hFF) begin
                                r_drop_cnt <= r_drop_cnt + 8'd1;
                            end
                        end
                    end else if (wr_valid) begin
                        r_ovf_err <= 1'b1;
                    end
                end
                default: r_state <= WR_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_motion_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_motion_frame_buffer
// Description : Self-checking bench for motion_frame_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motion_frame_buffer;
    import motion_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_sof;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              rd_frame_start;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] prev_data;
    logic [DATA_W-1:0] curr_data;
    logic              frame_valid;
    logic              short_err;
    logic              ovf_err;
    logic [7:0]        drop_cnt;

    always #5 clk = ~clk;

    motion_frame_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .wr_sof         (wr_sof),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .rd_frame_start (rd_frame_start),
        .rd_addr        (rd_addr),
        .prev_data      (prev_data),
        .curr_data      (curr_data),
        .frame_valid    (frame_valid),
        .short_err      (short_err),
        .ovf_err        (ovf_err),
        .drop_cnt       (drop_cnt)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       exp_curr;
        logic [15:0]       exp_prev;
    } rd_vec_t;

    typedef struct {
        logic [15:0] c;
        logic [15:0] p;
    } exp_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    exp_t   sb_q[$];
    logic   rd_req = 1'b0;
    logic   rd_vld_d = 1'b0;

    // Pixel content per frame pattern; anything past a full frame is junk.
    function automatic logic [15:0] pix(input int pat, input int i);
        logic [15:0] v;
        v = 16'(i);
        if (i >= PIX_CNT) return 16'hDEAD;
        case (pat)
            0:       return v;
            1:       return ~v;
            2:       return v ^ 16'h5A5A;
            3:       return v + 16'h3C00;
            default: return v ^ 16'hA5A5;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_vld_d <= rd_req;

    always @(negedge clk) begin
        exp_t e;
        if (rd_vld_d) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_scoreboard: output with no expected entry");
            end else begin
                e = sb_q.pop_front();
                if (curr_data !== e.c || prev_data !== e.p) begin
                    n_bad++;
                    $display("FAIL rd_data: got curr=%h prev=%h want curr=%h prev=%h",
                             curr_data, prev_data, e.c, e.p);
                end
            end
        end
    end

    task automatic issue_read(input int a, input logic [15:0] ec, input logic [15:0] ep);
        exp_t e;
        @(negedge clk);
        rd_addr = ADDR_W'(a);
        rd_req  = 1'b1;
        e.c = ec;
        e.p = ep;
        sb_q.push_back(e);
    endtask

    task automatic end_reads();
        @(negedge clk);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rd_drain", sb_q.size(), 0);
    endtask

    task automatic stream(input bit sof, input int start, input int n, input int pat);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_sof   = sof && (i == 0);
            wr_valid = 1'b1;
            wr_data  = pix(pat, start + i);
        end
        @(negedge clk);
        wr_sof   = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic pulse_rfs();
        @(negedge clk);
        rd_frame_start = 1'b1;
        @(negedge clk);
        rd_frame_start = 1'b0;
    endtask

    rd_vec_t vecs [8];

    initial begin
        int va [8];
        va = '{0, 5, 159, 160, 9000, PIX_CNT-1, PIX_CNT, 32767};
        for (int i = 0; i < 8; i++) begin
            vecs[i].addr     = ADDR_W'(va[i]);
            vecs[i].exp_curr = (va[i] < PIX_CNT) ? pix(1, va[i]) : 16'h0000;
            vecs[i].exp_prev = (va[i] < PIX_CNT) ? pix(0, va[i]) : 16'h0000;
        end

        reset = 1'b0; wr_sof = 1'b0; wr_valid = 1'b0; wr_data = '0;
        rd_frame_start = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_curr", curr_data, 0);
        chk("rst_prev", prev_data, 0);
        chk("rst_fvalid", frame_valid, 0);
        chk("rst_errs", {short_err, ovf_err}, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_banks", {dut.r_wr_bank, dut.r_curr_bank, dut.r_prev_bank}, 6'b00_01_10);
        reset = 1'b1;

        // Frame A, rotate; frame B with 5 surplus pixels, rotate.
        stream(1'b1, 0, PIX_CNT, 0);
        chk("a_fvalid", frame_valid, 0);
        pulse_rfs();
        chk("a_rot_fvalid", frame_valid, 0);
        stream(1'b1, 0, PIX_CNT + 5, 1);
        chk("b_ovf", ovf_err, 1);
        chk("b_short", short_err, 0);
        pulse_rfs();
        chk("b_fvalid", frame_valid, 1);
        for (int i = 0; i < 8; i++) issue_read(int'(vecs[i].addr), vecs[i].exp_curr, vecs[i].exp_prev);
        end_reads();

        // Short frame, then a rotation request with nothing pending.
        stream(1'b1, 0, 100, 2);
        chk("pre_short", short_err, 0);
        stream(1'b1, 0, 10, 2);
        chk("short_err", short_err, 1);
        pulse_rfs();
        issue_read(5, 16'hFFFA, 16'h0005);
        end_reads();
        chk("short_fvalid", frame_valid, 1);
        stream(1'b0, 10, PIX_CNT - 10, 2);
        chk("c_drop", drop_cnt, 0);

        // Frame D overwrites the unshown frame C.
        stream(1'b1, 0, PIX_CNT, 3);
        chk("d_drop", drop_cnt, 1);
        issue_read(7, pix(1, 7), pix(0, 7));
        end_reads();

        // Rotation and frame start in the same cycle.
        @(negedge clk);
        wr_sof = 1'b1; rd_frame_start = 1'b1; wr_valid = 1'b1; wr_data = pix(4, 0);
        @(negedge clk);
        wr_sof = 1'b0; rd_frame_start = 1'b0; wr_valid = 1'b0;
        chk("e_drop", drop_cnt, 1);
        stream(1'b0, 1, 8999, 4);
        issue_read(0, pix(3, 0), pix(1, 0));
        issue_read(100, pix(3, 100), pix(1, 100));
        issue_read(8999, pix(3, 8999), pix(1, 8999));
        issue_read(PIX_CNT - 1, pix(3, PIX_CNT - 1), pix(1, PIX_CNT - 1));
        end_reads();
        chk("e_ptr", dut.r_wr_ptr, 9000);
        chk("e_errs", {frame_valid, short_err, ovf_err}, 3'b111);

        // Reset mid-frame.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_out", {curr_data, prev_data}, 0);
        chk("mrst_flags", {frame_valid, short_err, ovf_err, drop_cnt}, 0);
        chk("mrst_banks", {dut.r_wr_bank, dut.r_curr_bank, dut.r_prev_bank}, 6'b00_01_10);
        chk("mrst_ptr", {dut.r_pending, dut.r_wr_ptr}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
